// File: rtl/driver_cycle_mon_pkg.sv
// -----------------------------------------------------------------------------
// driver_mon_pkg
// Shared types and helpers for the driver FIFO cycle monitor.
//   mon_state_t : monitor FSM state encoding (IDLE / ARMED / RUN)
//   SAT16       : saturation value of the 16-bit interval counter
//   calc_bin    : value / range, clamped to the last of nbins bins
// -----------------------------------------------------------------------------
package driver_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } mon_state_t;

    localparam logic [15:0] SAT16 = 16'hFFFF;

    // Anything past the covered span lands in the last bin.
    function automatic int unsigned calc_bin(input logic [15:0]  value,
                                             input int unsigned  range,
                                             input int unsigned  nbins);
        int unsigned q;
        q = 32'(value) / range;
        if (q > nbins - 1) begin
            q = nbins - 1;
        end
        return q;
    endfunction

endpackage

// File: rtl/driver_cycle_mon_if.sv
// -----------------------------------------------------------------------------
// driver_cycle_mon_if
// FIFO-side strobe bundle observed by the cycle monitor.
//   program_start  : 1-cycle pulse, clears statistics and arms the monitor
//   active_program : measurement enable
//   fifo_pop       : 1-cycle strobe per word consumed from the FIFO
//   words_in_fifo  : FIFO occupancy, valid alongside fifo_pop
// master = FIFO/driver side (drives), slave = monitor (observes).
// -----------------------------------------------------------------------------
interface driver_cycle_mon_if;

    logic        program_start;
    logic        active_program;
    logic        fifo_pop;
    logic [15:0] words_in_fifo;

    modport master (
        output program_start,
        output active_program,
        output fifo_pop,
        output words_in_fifo
    );

    modport slave (
        input  program_start,
        input  active_program,
        input  fifo_pop,
        input  words_in_fifo
    );

endinterface

// File: rtl/driver_cycle_mon_hist_bank.sv
// -----------------------------------------------------------------------------
// mon_hist_bank
// Array of saturating histogram counters, one per bin.
//   clk, reset : clock, async active-high reset
//   clear      : synchronous clear of every counter (wins over inc_valid)
//   inc_valid  : increment the counter selected by inc_idx
//   inc_idx    : bin to increment
//   cnts       : counter array, registered
// Counters are incremented in place from their own flops, so increments on
// consecutive cycles to the same bin all land.
// -----------------------------------------------------------------------------
module mon_hist_bank #(
    parameter  int NUM_BINS = 16,
    parameter  int CNT_W    = 16,
    localparam int IDX_W    = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clear,
    input  logic                               inc_valid,
    input  logic [IDX_W-1:0]                   inc_idx,
    output logic [NUM_BINS-1:0][CNT_W-1:0]     cnts
);

    logic [NUM_BINS-1:0][CNT_W-1:0] cnts_q;
    logic [NUM_BINS-1:0][CNT_W-1:0] cnts_d;

    always_comb begin
        cnts_d = cnts_q;
        if (clear) begin
            cnts_d = '0;
        end else if (inc_valid && (cnts_q[inc_idx] != {CNT_W{1'b1}})) begin
            // Stop at all-ones rather than wrapping back to zero.
            cnts_d[inc_idx] = cnts_q[inc_idx] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnts_q <= '0;
        end else begin
            cnts_q <= cnts_d;
        end
    end

    assign cnts = cnts_q;

endmodule

// File: rtl/driver_cycle_mon.sv
// -----------------------------------------------------------------------------
// driver_cycle_mon
// Measures clk cycles between consecutive FIFO pops during an active program
// and histograms both the interval and the FIFO fill level seen at each pop.
//   clk, reset     : clock, async active-high reset
//   mon_if         : FIFO strobe bundle (program_start, active_program,
//                    fifo_pop, words_in_fifo)
//   cycle_cnt      : last measured interval
//   mon_cnts       : interval histogram, MON_CNT_RANGE cycles per bin
//   fifo_mon_cnts  : fill-level histogram, bin = words_in_fifo >> LEVEL_SHIFT
//   interval_sat   : sticky, an interval reached 16'hFFFF
//
// State table
//   state | meaning
//   IDLE  | not measuring; pops ignored until program_start
//   ARMED | stats cleared; first pop only starts the interval timer
//   RUN   | timing; each pop closes an interval and feeds the histograms
//
// Pipeline: a pop in RUN captures ivl/bin/lvl in S1; the next cycle (S2) the
// histogram banks increment and cycle_cnt loads, so results show 2 cycles
// after the pop.
// -----------------------------------------------------------------------------
module driver_cycle_mon
    import driver_mon_pkg::*;
#(
    parameter  int MON_CNT_RANGE = 8,
    parameter  int MON_CNT_SIZE  = 16,
    parameter  int MAX_CYCLE_CNT = 128,
    parameter  int LEVEL_SHIFT   = 6,
    localparam int NUM_BINS      = MAX_CYCLE_CNT / MON_CNT_RANGE,
    localparam int BIN_W         = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    driver_cycle_mon_if.slave                      mon_if,
    output logic [15:0]                            cycle_cnt,
    output logic [NUM_BINS-1:0][MON_CNT_SIZE-1:0]  mon_cnts,
    output logic [NUM_BINS-1:0][MON_CNT_SIZE-1:0]  fifo_mon_cnts,
    output logic                                   interval_sat
);

    logic        start;
    logic        active;
    logic        pop;
    logic [15:0] words;

    assign start  = mon_if.program_start;
    assign active = mon_if.active_program;
    assign pop    = mon_if.fifo_pop;
    assign words  = mon_if.words_in_fifo;

    mon_state_t  state_q, state_d;

    logic        pop_arm;
    logic        pop_take;
    logic        cnt_run;

    logic [15:0] ivl_cnt_q, ivl_cnt_d;
    logic [15:0] ivl;

    logic             s1_valid_q, s1_valid_d;
    logic [15:0]      s1_ivl_q,   s1_ivl_d;
    logic [BIN_W-1:0] s1_bin_q,   s1_bin_d;
    logic [BIN_W-1:0] s1_lvl_q,   s1_lvl_d;

    logic        s2_fire;
    logic [15:0] cycle_cnt_q, cycle_cnt_d;
    logic        interval_sat_q, interval_sat_d;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ARMED;
        end else if (!active) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                ARMED:   if (pop) state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    // program_start drops any pop in the same cycle.
    always_comb begin
        pop_arm  = 1'b0;
        pop_take = 1'b0;
        cnt_run  = 1'b0;
        case (state_q)
            ARMED: begin
                pop_arm = pop && active && !start;
            end
            RUN: begin
                cnt_run  = 1'b1;
                pop_take = pop && active && !start;
            end
            default: begin
                pop_arm  = 1'b0;
                pop_take = 1'b0;
            end
        endcase
    end

    // ----------------------------------------------------- interval counter
    // The counter holds cycles elapsed since the last pop minus one, so the
    // interval closed by a pop is counter+1 (saturating).
    assign ivl = (ivl_cnt_q == SAT16) ? SAT16 : ivl_cnt_q + 16'd1;

    always_comb begin
        ivl_cnt_d = ivl_cnt_q;
        if (start || pop_arm || pop_take) begin
            ivl_cnt_d = '0;
        end else if (cnt_run && (ivl_cnt_q != SAT16)) begin
            ivl_cnt_d = ivl_cnt_q + 16'd1;
        end
    end

    // ----------------------------------------------------------- stage S1
    always_comb begin
        s1_valid_d = pop_take;
        s1_ivl_d   = s1_ivl_q;
        s1_bin_d   = s1_bin_q;
        s1_lvl_d   = s1_lvl_q;
        if (pop_take) begin
            s1_ivl_d = ivl;
            s1_bin_d = BIN_W'(calc_bin(ivl, MON_CNT_RANGE, NUM_BINS));
            s1_lvl_d = BIN_W'(calc_bin(words, 32'd1 << LEVEL_SHIFT, NUM_BINS));
        end
    end

    // ----------------------------------------------------------- stage S2
    // An S1 entry still completes after active_program drops, but a
    // program_start in the same cycle discards it.
    assign s2_fire = s1_valid_q && !start;

    always_comb begin
        cycle_cnt_d    = cycle_cnt_q;
        interval_sat_d = interval_sat_q;
        if (start) begin
            cycle_cnt_d    = '0;
            interval_sat_d = 1'b0;
        end else if (s2_fire) begin
            cycle_cnt_d = s1_ivl_q;
            if (s1_ivl_q == SAT16) begin
                interval_sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ivl_cnt_q      <= '0;
            s1_valid_q     <= 1'b0;
            s1_ivl_q       <= '0;
            s1_bin_q       <= '0;
            s1_lvl_q       <= '0;
            cycle_cnt_q    <= '0;
            interval_sat_q <= 1'b0;
        end else begin
            ivl_cnt_q      <= ivl_cnt_d;
            s1_valid_q     <= s1_valid_d;
            s1_ivl_q       <= s1_ivl_d;
            s1_bin_q       <= s1_bin_d;
            s1_lvl_q       <= s1_lvl_d;
            cycle_cnt_q    <= cycle_cnt_d;
            interval_sat_q <= interval_sat_d;
        end
    end

    // ------------------------------------------------------ histogram banks
    mon_hist_bank #(
        .NUM_BINS (NUM_BINS),
        .CNT_W    (MON_CNT_SIZE)
    ) u_ivl_bank (
        .clk       (clk),
        .reset     (reset),
        .clear     (start),
        .inc_valid (s2_fire),
        .inc_idx   (s1_bin_q),
        .cnts      (mon_cnts)
    );

    mon_hist_bank #(
        .NUM_BINS (NUM_BINS),
        .CNT_W    (MON_CNT_SIZE)
    ) u_lvl_bank (
        .clk       (clk),
        .reset     (reset),
        .clear     (start),
        .inc_valid (s2_fire),
        .inc_idx   (s1_lvl_q),
        .cnts      (fifo_mon_cnts)
    );

    assign cycle_cnt    = cycle_cnt_q;
    assign interval_sat = interval_sat_q;

endmodule

// File: tb/tb_driver_cycle_mon.sv
// -----------------------------------------------------------------------------
// tb_driver_cycle_mon
// Directed and randomized stimulus against two monitors sharing one strobe
// bundle: default counter width, and a 4-bit counter variant that exposes
// bin saturation. Expected values come from an event-level model that works
// from pop timestamps rather than a cycle-by-cycle counter.
// -----------------------------------------------------------------------------
module tb_driver_cycle_mon;

    logic clk;
    logic reset;

    driver_cycle_mon_if bus_if ();

    logic [15:0]            cycle_cnt,  cycle_cnt4;
    logic [15:0][15:0]      mon_cnts,   fifo_mon_cnts;
    logic [15:0][3:0]       mon_cnts4,  fifo_mon_cnts4;
    logic                   interval_sat, interval_sat4;

    driver_cycle_mon dut (
        .clk           (clk),
        .reset         (reset),
        .mon_if        (bus_if),
        .cycle_cnt     (cycle_cnt),
        .mon_cnts      (mon_cnts),
        .fifo_mon_cnts (fifo_mon_cnts),
        .interval_sat  (interval_sat)
    );

    driver_cycle_mon #(.MON_CNT_SIZE(4)) dut4 (
        .clk           (clk),
        .reset         (reset),
        .mon_if        (bus_if),
        .cycle_cnt     (cycle_cnt4),
        .mon_cnts      (mon_cnts4),
        .fifo_mon_cnts (fifo_mon_cnts4),
        .interval_sat  (interval_sat4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    typedef enum {M_IDLE, M_ARMED, M_RUN} m_mode_t;

    m_mode_t m_mode;
    longint  cyc;
    longint  last_pop;
    int      m_hist [16];
    int      m_lvl  [16];
    int      m_cycle;
    bit      m_sat;

    int n_pass;
    int n_total;

    function automatic void model_clear();
        for (int b = 0; b < 16; b++) begin
            m_hist[b] = 0;
            m_lvl[b]  = 0;
        end
        m_cycle = 0;
        m_sat   = 1'b0;
    endfunction

    // One clock edge as seen by the monitor.
    function automatic void model_step(input bit st, input bit pp,
                                       input int w, input bit act);
        longint ivl;
        int     bi, li;
        if (st) begin
            model_clear();
            m_mode = M_ARMED;
            return;
        end
        if (act && pp && m_mode == M_RUN) begin
            ivl = cyc - last_pop;
            if (ivl > 65535) ivl = 65535;
            bi = int'(ivl / 8);
            if (bi > 15) bi = 15;
            li = w / 64;
            if (li > 15) li = 15;
            m_hist[bi]++;
            m_lvl[li]++;
            m_cycle = int'(ivl);
            if (ivl == 65535) m_sat = 1'b1;
            last_pop = cyc;
        end else if (act && pp && m_mode == M_ARMED) begin
            m_mode   = M_RUN;
            last_pop = cyc;
        end
        if (!act) m_mode = M_IDLE;
    endfunction

    function automatic int cap(input int v, input int bits);
        int lim;
        lim = (1 << bits) - 1;
        return (v > lim) ? lim : v;
    endfunction

    // ------------------------------------------------------------- checking
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".cycle_cnt"},  32'(cycle_cnt),     32'(m_cycle));
        chk({tag, ".cycle_cnt4"}, 32'(cycle_cnt4),    32'(m_cycle));
        chk({tag, ".sat"},        32'(interval_sat),  32'(m_sat));
        chk({tag, ".sat4"},       32'(interval_sat4), 32'(m_sat));
        for (int b = 0; b < 16; b++) begin
            chk($sformatf("%s.mon[%0d]", tag, b),   32'(mon_cnts[b]),       32'(cap(m_hist[b], 16)));
            chk($sformatf("%s.fifo[%0d]", tag, b),  32'(fifo_mon_cnts[b]),  32'(cap(m_lvl[b], 16)));
            chk($sformatf("%s.mon4[%0d]", tag, b),  32'(mon_cnts4[b]),      32'(cap(m_hist[b], 4)));
            chk($sformatf("%s.fifo4[%0d]", tag, b), 32'(fifo_mon_cnts4[b]), 32'(cap(m_lvl[b], 4)));
        end
    endtask

    // ------------------------------------------------------------- stimulus
    // Called at a negedge; drives for one posedge and returns at the next negedge.
    task automatic tick(input bit st, input bit pp, input logic [15:0] w);
        bus_if.program_start = st;
        bus_if.fifo_pop      = pp;
        bus_if.words_in_fifo = w;
        @(posedge clk);
        model_step(st, pp, int'(w), bus_if.active_program);
        cyc++;
        @(negedge clk);
        bus_if.program_start = 1'b0;
        bus_if.fifo_pop      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'd0);
    endtask

    initial begin
        int gap;
        n_pass   = 0;
        n_total  = 0;
        cyc      = 0;
        last_pop = 0;
        m_mode   = M_IDLE;
        model_clear();

        reset                 = 1'b1;
        bus_if.program_start  = 1'b0;
        bus_if.active_program = 1'b0;
        bus_if.fifo_pop       = 1'b0;
        bus_if.words_in_fifo  = 16'd0;
        repeat (3) @(negedge clk);
        check_all("reset");
        reset = 1'b0;
        idle(2);

        // Back-to-back pops: first arms, next two give ivl=1.
        bus_if.active_program = 1'b1;
        tick(1'b1, 1'b0, 16'd0);
        tick(1'b0, 1'b1, 16'd70);
        tick(1'b0, 1'b1, 16'd70);
        tick(1'b0, 1'b1, 16'd70);
        idle(1);
        chk("b2b.mon0",   32'(mon_cnts[0]),      32'd2);
        chk("b2b.cycle",  32'(cycle_cnt),        32'd1);
        chk("b2b.fifo1",  32'(fifo_mon_cnts[1]), 32'd2);
        idle(2);
        check_all("b2b");

        // Three pops 20 cycles apart at fill 200.
        tick(1'b1, 1'b0, 16'd0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b1, 16'd200);
            if (k < 2) idle(19);
        end
        idle(3);
        chk("gap20.mon2",  32'(mon_cnts[2]),      32'd2);
        chk("gap20.fifo3", 32'(fifo_mon_cnts[3]), 32'd2);
        chk("gap20.cycle", 32'(cycle_cnt),        32'd20);
        check_all("gap20");

        // Clamp edges: 119 -> bin 14; 120, 128, 127 -> bin 15; fill clamps too.
        tick(1'b1, 1'b0, 16'd0);
        tick(1'b0, 1'b1, 16'd0);
        idle(118); tick(1'b0, 1'b1, 16'd959);
        idle(119); tick(1'b0, 1'b1, 16'd960);
        idle(127); tick(1'b0, 1'b1, 16'hFFFF);
        idle(126); tick(1'b0, 1'b1, 16'd63);
        idle(3);
        chk("clamp.mon14", 32'(mon_cnts[14]), 32'd1);
        chk("clamp.mon15", 32'(mon_cnts[15]), 32'd3);
        check_all("clamp");

        // Long intervals: 500, then 70000 (saturates).
        tick(1'b1, 1'b0, 16'd0);
        tick(1'b0, 1'b1, 16'd10);
        idle(499); tick(1'b0, 1'b1, 16'd10);
        idle(3);
        chk("long500.cycle", 32'(cycle_cnt),    32'd500);
        chk("long500.sat",   32'(interval_sat), 32'd0);
        check_all("long500");
        idle(70000 - 4); tick(1'b0, 1'b1, 16'd10);
        idle(3);
        chk("long70k.mon15", 32'(mon_cnts[15]), 32'd2);
        chk("long70k.cycle", 32'(cycle_cnt),    32'hFFFF);
        chk("long70k.sat",   32'(interval_sat), 32'd1);
        check_all("long70k");

        // 20 back-to-back pops: 19 intervals, 4-bit bank stops at 15.
        tick(1'b1, 1'b0, 16'd0);
        for (int k = 0; k < 20; k++) tick(1'b0, 1'b1, 16'd5);
        idle(3);
        chk("sat4.mon4_0", 32'(mon_cnts4[0]), 32'hF);
        chk("sat4.mon0",   32'(mon_cnts[0]),  32'd19);
        check_all("sat4");

        // program_start colliding with a pop and an in-flight S1 entry.
        tick(1'b0, 1'b1, 16'd5);
        tick(1'b1, 1'b1, 16'd5);
        idle(2);
        chk("startpop.mon0", 32'(mon_cnts[0]), 32'd0);
        check_all("startpop");
        tick(1'b0, 1'b1, 16'd5);
        idle(3);
        check_all("startpop.arm");
        idle(1); tick(1'b0, 1'b1, 16'd5);
        idle(3);
        chk("startpop.cycle", 32'(cycle_cnt), 32'd5);
        check_all("startpop.run");

        // active_program drops right after a pop: in-flight entry completes.
        tick(1'b0, 1'b1, 16'd300);
        bus_if.active_program = 1'b0;
        idle(3);
        check_all("actdrop");
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 16'd300);
        bus_if.active_program = 1'b1;
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 16'd300);
        idle(3);
        check_all("idlepops");

        // Randomized rounds.
        for (int r = 0; r < 4; r++) begin
            tick(1'b1, 1'b0, 16'd0);
            for (int k = 0; k < 40; k++) begin
                tick(($urandom_range(0, 39) == 0), 1'b1, 16'($urandom_range(0, 1100)));
                gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 300))
                                                  : int'($urandom_range(0, 20));
                idle(gap);
            end
            idle(3);
            check_all($sformatf("rand%0d", r));
        end

        // Async reset mid-RUN.
        tick(1'b1, 1'b0, 16'd0);
        tick(1'b0, 1'b1, 16'd100);
        idle(3);
        tick(1'b0, 1'b1, 16'd100);
        #2 reset = 1'b1;
        #1;
        model_clear();
        m_mode = M_IDLE;
        chk("rst.cycle_now", 32'(cycle_cnt), 32'd0);
        check_all("rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 16'd100);
        idle(3);
        check_all("rst.ignored");
        tick(1'b1, 1'b0, 16'd0);
        tick(1'b0, 1'b1, 16'd100);
        idle(6);
        tick(1'b0, 1'b1, 16'd100);
        idle(3);
        chk("rst.rearm.cycle", 32'(cycle_cnt), 32'd7);
        check_all("rst.rearm");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
